cnt_run_ctrl: RTL and testbench
===============================

// Module: cnt_run_ctrl
// PURPOSE
//  Run controller for a WIDTH-bit event counter: owns the count register and sequences it.
//  - Start/stop/clear command FSM with a prescaled count enable.
//  - Programmable terminal value; terminal-count reporting.
//  - Sits between the panel/command logic and the counter display path.
//  - Replaces free-running counters where gated, bounded counting is needed.
// PARAMETERS
//  WIDTH       4  count and limit width in bits
//  PRESCALE_W  4  prescaler divisor width in bits
// PORTS
//  CLK0   in   1           clock, rising edge
//  RST    in   1           reset, asynchronous, active-low
//  start  in   1           start from IDLE/DONE, or resume from HOLD (level sampled each edge)
//  stop   in   1           pause RUN -> HOLD
//  clr    in   1           synchronous abort to IDLE, highest priority
//  limit  in   WIDTH       terminal count value, sampled on start from IDLE/DONE
//  div    in   PRESCALE_W  prescale divisor: count advances every div+1 RUN cycles
//  count  out  WIDTH       current count
//  tick   out  1           1-cycle pulse, registered with each count update
//  wrap   out  1           1-cycle pulse on terminal event
//  busy   out  1           1 in RUN or HOLD
//  done   out  1           1 while in DONE
//  state  out  2           IDLE=00 RUN=01 HOLD=10 DONE=11
// BEHAVIOUR
//  - Reset (RST=0, async):
//    - state=IDLE; count, tick, wrap, busy, done all 0.
//    - Prescaler pre, limit_q and div_q all 0.
//  - Command priority, evaluated per rising edge: clr > stop > start.
//  - clr, any state: -> IDLE; count=0, pre=0, done=0; tick/wrap suppressed that edge.
//  - start in IDLE/DONE: -> RUN; count=0, pre=0; limit_q<=limit, div_q<=div.
//  - start in HOLD: -> RUN; count and pre retained (resume).
//  - start in RUN: ignored.
//  - stop in RUN: -> HOLD; count and pre frozen.
//  - stop in IDLE/HOLD/DONE: ignored.
//  - limit/div changes outside a start-from-IDLE/DONE edge have no effect.
//  - Prescaler, RUN only:
//    - If pre==div_q at an edge: pre<=0 and a count step occurs. Otherwise pre<=pre+1.
//    - div_q=0 gives a step on every RUN edge.
//  - Count step:
//    - If count!=limit_q: count<=count+1, tick=1 for the next cycle.
//    - If count==limit_q: terminal event; tick=1 and wrap=1 for the next cycle.
//    - Sequence is 0..limit_q, i.e. limit_q+1 steps per period; limit_q=0 makes every step terminal.
//  - stop and a step due on the same edge: stop wins; no step, pre unchanged.
//  - Latency: start at edge k -> state=RUN after edge k. With div=0, count=1 and tick=1 after edge k+1.
//  - busy, done and state are registered and decode the current state.
//  - Reset mid-operation: immediate return to reset values; no pulse is emitted.
// CONFIGURATION
//  AUTO_RELOAD_EN defined:
//    - Terminal event: count<=0, state stays RUN, done never asserts.
//    - limit_q/div_q re-sampled from limit/div at each terminal event.
//  AUTO_RELOAD_EN undefined:
//    - Terminal event: -> DONE; count holds limit_q; done=1 until start or clr.
//  wrap pulses on the terminal event in both builds.
// TESTING
//  1 Reset: RST=0 mid-RUN with count=5 -> all outputs 0 and state=00 asynchronously, before the next edge.
//  2 One-shot, no AUTO_RELOAD_EN, limit=3, div=0, start 1 cycle:
//    - count 1,2,3 on successive edges, then wrap=1, state=11, done=1, count=3.
//  3 Prescale, div=2, limit=1:
//    - tick every 3rd edge; count 0->1 at edge k+3; terminal at edge k+6.
//  4 Pause/resume, div=0, limit=9:
//    - stop when count=4 -> state=10, count stays 4 over 5 cycles.
//    - start -> count=5 on the second edge after it.
//  5 Priority: start=stop=clr=1 while in RUN, count=6 -> state=00, count=0, no tick.
//  6 With AUTO_RELOAD_EN, limit=2, div=0:
//    - count 0,1,2,0,1,2...; wrap pulses every 3 edges; done stays 0; busy stays 1.

Source files
------------

// File: rtl/cnt_run_ctrl.sv
// cnt_run_ctrl: run controller for a WIDTH-bit event counter.
// Sequences a count register through IDLE/RUN/HOLD/DONE using start/stop/clr
// commands. The count advances once every div+1 RUN cycles and wraps or
// terminates at a programmable limit.
// Optional feature macro: AUTO_RELOAD_EN. When it is defined, the terminal
// event reloads the count to 0 and stays in RUN. When it is undefined, the
// terminal event parks the block in DONE.
// Ports:
//   CLK0   clock, rising edge
//   RST    asynchronous active-low reset
//   start  start from IDLE/DONE, or resume from HOLD
//   stop   pause RUN -> HOLD
//   clr    synchronous abort to IDLE; highest priority
//   limit  terminal count value, captured on start from IDLE/DONE
//   div    prescale divisor, captured on start from IDLE/DONE
//   count  current count
//   tick   one-cycle pulse accompanying each count step
//   wrap   one-cycle pulse on the terminal event
//   busy   high in RUN or HOLD
//   done   high in DONE
//   state  IDLE=00 RUN=01 HOLD=10 DONE=11
module cnt_run_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  CLK0,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t                st_q, st_n;
  logic [WIDTH-1:0]      count_n;
  logic [WIDTH-1:0]      lim_q, lim_n;
  logic [PRESCALE_W-1:0] div_q, div_n;
  logic [PRESCALE_W-1:0] pre_q, pre_n;
  logic                  tick_n, wrap_n, busy_n, done_n;

  assign state = st_q;

  // State and datapath registers
  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      st_q  <= S_IDLE;
      count <= '0;
      lim_q <= '0;
      div_q <= '0;
      pre_q <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      st_q  <= st_n;
      count <= count_n;
      lim_q <= lim_n;
      div_q <= div_n;
      pre_q <= pre_n;
      tick  <= tick_n;
      wrap  <= wrap_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state, prescaler and count-step logic
  always_comb begin
    st_n    = st_q;
    count_n = count;
    lim_n   = lim_q;
    div_n   = div_q;
    pre_n   = pre_q;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;

    if (clr) begin
      st_n    = S_IDLE;
      count_n = '0;
      pre_n   = '0;
    end else begin
      case (st_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            st_n    = S_RUN;
            count_n = '0;
            pre_n   = '0;
            lim_n   = limit;
            div_n   = div;
          end
        end
        S_RUN: begin
          // stop takes precedence over a step due on the same edge
          if (stop) begin
            st_n = S_HOLD;
          end else if (pre_q == div_q) begin
            pre_n  = '0;
            tick_n = 1'b1;
            if (count != lim_q) begin
              count_n = count + WIDTH'(1);
            end else begin
              wrap_n = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_n = '0;
              lim_n   = limit;
              div_n   = div;
`else
              st_n    = S_DONE;
`endif
            end
          end else begin
            pre_n = pre_q + PRESCALE_W'(1);
          end
        end
        S_HOLD: begin
          // resume keeps count and prescaler phase
          if (start) st_n = S_RUN;
        end
        default: st_n = S_IDLE;
      endcase
    end

    busy_n = (st_n == S_RUN) || (st_n == S_HOLD);
    done_n = (st_n == S_DONE);
  end

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Directed testbench for cnt_run_ctrl (WIDTH=4, PRESCALE_W=4).
module tb_cnt_run_ctrl;

  logic       CLK0 = 1'b0;
  logic       RST;
  logic       start, stop, clr;
  logic [3:0] limit, div;
  logic [3:0] count;
  logic       tick, wrap, busy, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  cnt_run_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .CLK0  (CLK0),
    .RST   (RST),
    .start (start),
    .stop  (stop),
    .clr   (clr),
    .limit (limit),
    .div   (div),
    .count (count),
    .tick  (tick),
    .wrap  (wrap),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 CLK0 = ~CLK0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output at once
  task automatic chk_all(input string tag, input logic [1:0] e_state, input logic [3:0] e_count,
                         input logic e_tick, input logic e_wrap, input logic e_busy,
                         input logic e_done);
    chk({tag, ".state"}, 32'(state), 32'(e_state));
    chk({tag, ".count"}, 32'(count), 32'(e_count));
    chk({tag, ".tick"},  32'(tick),  32'(e_tick));
    chk({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge CLK0);
    #1;
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; limit = 4'd0; div = 4'd0;
    #2;
    chk_all("reset", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    RST = 1'b1;

    // One-shot: limit=3, div=0
    limit = 4'd3; div = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk_all("os_start", 2'b01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os_c1", 2'b01, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os_c2", 2'b01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os_c3", 2'b01, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os_term", 2'b11, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); chk_all("os_done_hold", 2'b11, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    // Prescale: div=2, limit=1; later limit/div changes must be ignored
    limit = 4'd1; div = 4'd2; start = 1'b1;
    step(); start = 1'b0; limit = 4'd7; div = 4'd0;
    chk_all("ps_start", 2'b01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k1", 2'b01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k2", 2'b01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k3", 2'b01, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k4", 2'b01, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k5", 2'b01, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("ps_k6", 2'b11, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);

    // clr from DONE returns to IDLE
    clr = 1'b1;
    step(); clr = 1'b0;
    chk_all("clr_done", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause/resume: limit=9, div=0
    limit = 4'd9; div = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("pr_start.count", 32'(count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("pr_run.count", 32'(count), 32'(i));
    end
    stop = 1'b1;
    step(); stop = 1'b0;
    chk_all("pr_stop", 2'b10, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("pr_hold", 2'b10, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    start = 1'b1;
    step(); start = 1'b0;
    chk_all("pr_resume", 2'b01, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); chk_all("pr_c5", 2'b01, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);

    // Priority: all commands together in RUN at count=6
    step(); chk("pri_pre.count", 32'(count), 32'd6);
    start = 1'b1; stop = 1'b1; clr = 1'b1;
    step(); start = 1'b0; stop = 1'b0; clr = 1'b0;
    chk_all("pri_clr", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN at count=5
    limit = 4'd9; div = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_pre.count", 32'(count), 32'd5);
    #2 RST = 1'b0;
    #1 chk_all("rst_async", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rst_held", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;

`ifdef AUTO_RELOAD_EN
    // Auto reload: limit=2, div=0 -> 0,1,2,0,1,2...
    limit = 4'd2; div = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk_all("ar_start", 2'b01, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk_all("ar_run", 2'b01, 4'(j % 3), 1'b1, ((j % 3) == 0), 1'b1, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
